// File: rtl/fc_pkg.sv
// ============================================================================
// Module   : fc_pkg
// Brief    : Shared lane geometry, FSM state encoding and lane-extract helper
//            for the FC result-stream argmax stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lane 0 sits in the least significant byte.
    function automatic logic [LANE_W-1:0] lane_extract(
        input logic [LANES*LANE_W-1:0] data,
        input logic [1:0]              idx
    );
        return data[idx*LANE_W +: LANE_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_axis_skid.sv
// ============================================================================
// Module   : fc_axis_skid
// Brief    : Two-entry AXIS register slice with a registered upstream ready.
//            Full throughput, no combinational ready path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_axis_skid #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_s_en,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_next;
    logic             r_s_ready;
    logic             w_push;
    logic             w_pop;

    assign w_push    = i_s_valid && r_s_ready;
    assign w_pop     = (r_cnt != 2'd0) && i_m_ready;
    assign o_s_ready = r_s_ready;
    assign o_m_valid = (r_cnt != 2'd0);
    assign o_m_data  = r_mem[r_rd_ptr];

    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_cnt + 2'd1;
            2'b01:   w_cnt_next = r_cnt - 2'd1;
            default: w_cnt_next = r_cnt;
        endcase
    end

    // Ready for next cycle is decided from next occupancy, so a full slice
    // stalls upstream without looking at i_m_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_cnt     <= 2'd0;
            r_s_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_s_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt     <= w_cnt_next;
            r_s_ready <= i_s_en && (w_cnt_next != 2'd2);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fc_argmax_stream.sv
// ============================================================================
// Module   : fc_argmax_stream
// Brief    : Forwards the FC int8 result stream and tracks the running argmax.
//            Optional macro FC_ARGMAX_RELU_EN clamps negative forwarded lanes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_argmax_stream
    import fc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [DATA_W-1:0]    s_axis_tdata,
    input  logic [DATA_W/8-1:0]  s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic [DATA_W/8-1:0]  m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 busy,
    output logic                 argmax_done,
    output logic [CNT_W-1:0]     max_index,
    output logic [7:0]           max_value,
    output logic [CNT_W-1:0]     elem_count
);

    localparam int KEEP_W = DATA_W / LANE_W;
    localparam int PAY_W  = DATA_W + KEEP_W + 2;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_first_seen;
    logic [CNT_W-1:0]          r_max_index;
    logic [LANE_W-1:0]         r_max_value;
    logic [CNT_W-1:0]          r_elem_count;

    logic                      w_accept;
    logic                      w_restart;
    logic [DATA_W-1:0]         w_fwd_data;
    logic [PAY_W-1:0]          w_s_pay;
    logic [PAY_W-1:0]          w_m_pay;

    logic [CNT_W-1:0]          w_base_cnt;
    logic [CNT_W-1:0]          w_base_idx;
    logic signed [LANE_W-1:0]  w_base_val;
    logic                      w_base_seen;
    logic [CNT_W-1:0]          w_new_cnt;
    logic [CNT_W-1:0]          w_new_idx;
    logic signed [LANE_W-1:0]  w_new_val;
    logic                      w_new_seen;
    logic signed [LANE_W-1:0]  w_lane;
    logic [2:0]                w_pos;
    logic [CNT_W:0]            w_sum;

    assign w_accept  = s_axis_tvalid && s_axis_tready;
    // start in DONE is ignored; in RUN it restarts statistics immediately.
    assign w_restart = start && (r_state != DONE);

`ifdef FC_ARGMAX_RELU_EN
    logic [LANE_W-1:0] w_relu_lane;
    always_comb begin
        w_fwd_data  = s_axis_tdata;
        w_relu_lane = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            w_relu_lane = lane_extract(s_axis_tdata, i[1:0]);
            if (w_relu_lane[LANE_W-1]) begin
                w_fwd_data[i*LANE_W +: LANE_W] = '0;
            end
        end
    end
`else
    assign w_fwd_data = s_axis_tdata;
`endif

    assign w_s_pay = {w_fwd_data, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = w_m_pay;

    fc_axis_skid #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_s_en    (w_state_next == RUN),
        .i_s_valid (s_axis_tvalid),
        .o_s_ready (s_axis_tready),
        .i_s_data  (w_s_pay),
        .o_m_valid (m_axis_tvalid),
        .i_m_ready (m_axis_tready),
        .o_m_data  (w_m_pay)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_accept && s_axis_tlast) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Kept lanes are ranked in lane order; strict '>' keeps the lower index on ties.
    always_comb begin
        w_base_cnt  = w_restart ? '0   : r_elem_count;
        w_base_idx  = w_restart ? '0   : r_max_index;
        w_base_val  = w_restart ? '0   : $signed(r_max_value);
        w_base_seen = w_restart ? 1'b0 : r_first_seen;
        w_new_idx   = w_base_idx;
        w_new_val   = w_base_val;
        w_new_seen  = w_base_seen;
        w_pos       = '0;
        w_lane      = '0;
        w_sum       = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (s_axis_tkeep[i]) begin
                w_lane = $signed(lane_extract(s_axis_tdata, i[1:0]));
                w_sum  = {1'b0, w_base_cnt} + {{(CNT_W-2){1'b0}}, w_pos};
                if (!w_new_seen || (w_lane > w_new_val)) begin
                    w_new_val  = w_lane;
                    w_new_idx  = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
                    w_new_seen = 1'b1;
                end
                w_pos = w_pos + 3'd1;
            end
        end
        w_sum     = {1'b0, w_base_cnt} + {{(CNT_W-2){1'b0}}, w_pos};
        w_new_cnt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_first_seen <= 1'b0;
            r_max_index  <= '0;
            r_max_value  <= '0;
            r_elem_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == RUN);
            r_done  <= (w_state_next == DONE);
            if (w_accept) begin
                r_elem_count <= w_new_cnt;
                r_max_index  <= w_new_idx;
                r_max_value  <= w_new_val;
                r_first_seen <= w_new_seen;
            end else if (w_restart) begin
                r_elem_count <= '0;
                r_max_index  <= '0;
                r_max_value  <= '0;
                r_first_seen <= 1'b0;
            end
        end
    end

    assign busy        = r_busy;
    assign argmax_done = r_done;
    assign max_index   = r_max_index;
    assign max_value   = r_max_value;
    assign elem_count  = r_elem_count;

endmodule

`default_nettype wire

// File: tb/tb_fc_argmax_stream.sv
// ============================================================================
// Module   : tb_fc_argmax_stream
// Brief    : Self-checking bench for fc_argmax_stream with a forwarded-beat
//            scoreboard and per-scenario result checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fc_argmax_stream;

    localparam int CNT_W = 21;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic [31:0]      s_axis_tdata = '0;
    logic [3:0]       s_axis_tkeep = '0;
    logic             s_axis_tlast = 1'b0;
    logic             s_axis_tuser = 1'b0;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic [31:0]      m_axis_tdata;
    logic [3:0]       m_axis_tkeep;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic             busy;
    logic             argmax_done;
    logic [CNT_W-1:0] max_index;
    logic [7:0]       max_value;
    logic [CNT_W-1:0] elem_count;

    fc_argmax_stream #(.DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .argmax_done   (argmax_done),
        .max_index     (max_index),
        .max_value     (max_value),
        .elem_count    (elem_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_pulses = 0;
    int    stall_seen = 0;

    function automatic logic [31:0] fwd_model(input logic [31:0] d);
        logic [31:0] r;
        r = d;
`ifdef FC_ARGMAX_RELU_EN
        for (int i = 0; i < 4; i++) begin
            if (d[i*8+7]) r[i*8 +: 8] = 8'h00;
        end
`endif
        return r;
    endfunction

    // Negedge monitor: occupancy-vs-ready check, then output pop, then input push.
    always @(negedge clk) begin
        beat_t got;
        beat_t want;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (argmax_done) done_pulses++;
            if (busy && s_axis_tvalid && !s_axis_tready) stall_seen++;
            if (busy) begin
                checks++;
                if (s_axis_tready !== (exp_q.size() < 2)) begin
                    errors++;
                    $display("FAIL tready_vs_occupancy: got %b want %b (occupancy %0d)",
                             s_axis_tready, (exp_q.size() < 2), exp_q.size());
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h with empty scoreboard", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL forwarded_beat: got %h want %h", got, want);
                    end
                end
            end
            if (s_axis_tvalid && s_axis_tready)
                exp_q.push_back({fwd_model(s_axis_tdata), s_axis_tkeep, s_axis_tlast, s_axis_tuser});
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic u, output bit ok);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (argmax_done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
             busy, argmax_done, max_index, max_value, elem_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b mv=%b md=%h busy=%b done=%b idx=%0d val=%h cnt=%0d want all zero",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, busy, argmax_done,
                     max_index, max_value, elem_count);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int d0;
        do_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        d0 = done_pulses;
        send_beat(32'h057F8001, 4'hF, 1'b1, 1'b1, ok);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_done_timeout: got none want pulse"); end
        checks++;
        if ({max_index, max_value, elem_count} !== {21'd2, 8'h7F, 21'd4}) begin
            errors++;
            $display("FAIL single_result: got idx=%0d val=%h cnt=%0d want idx=2 val=7f cnt=4",
                     max_index, max_value, elem_count);
        end
        checks++;
        if (done_pulses - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_pulses - d0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b want 0", busy); end
    endtask

    task automatic test_ten_neurons();
        bit ok;
        do_start();
        send_beat(32'h05302010, 4'hF, 1'b0, 1'b0, ok);
        send_beat(32'h40030201, 4'hF, 1'b0, 1'b1, ok);
        send_beat(32'h7F7F113F, 4'h3, 1'b1, 1'b0, ok);
        wait_done(ok);
        checks++;
        if ({max_index, max_value, elem_count} !== {21'd7, 8'h40, 21'd10}) begin
            errors++;
            $display("FAIL ten_result: got idx=%0d val=%h cnt=%0d want idx=7 val=40 cnt=10",
                     max_index, max_value, elem_count);
        end
    endtask

    task automatic test_tie();
        bit ok;
        do_start();
        send_beat(32'h1F102000, 4'hF, 1'b0, 1'b0, ok);
        send_beat(32'h03200201, 4'hF, 1'b1, 1'b0, ok);
        wait_done(ok);
        checks++;
        if ({max_index, max_value, elem_count} !== {21'd1, 8'h20, 21'd8}) begin
            errors++;
            $display("FAIL tie_result: got idx=%0d val=%h cnt=%0d want idx=1 val=20 cnt=8",
                     max_index, max_value, elem_count);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        bit ok;
        int lost;
        lost = 0;
        stall_seen = 0;
        do_start();
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    send_beat({8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}, 4'hF,
                              (k == 4), k[0], ok);
                    if (!ok) lost++;
                end
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    m_axis_tready = ((c % 4) == 0) || ((c % 4) == 3);
                    @(posedge clk); #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_done(ok);
        checks++;
        if (lost != 0) begin errors++; $display("FAIL bp_accept_timeout: got %0d stuck beats want 0", lost); end
        checks++;
        if (stall_seen == 0) begin errors++; $display("FAIL bp_tready_drop: got 0 stall cycles want >0"); end
        checks++;
        if ({max_index, max_value, elem_count} !== {21'd19, 8'h14, 21'd20}) begin
            errors++;
            $display("FAIL bp_result: got idx=%0d val=%h cnt=%0d want idx=19 val=14 cnt=20",
                     max_index, max_value, elem_count);
        end
    endtask

    task automatic test_negative();
        bit ok;
        do_start();
        send_beat(32'hFF90FF80, 4'hF, 1'b0, 1'b0, ok);
        send_beat(32'h8180FFFE, 4'hF, 1'b1, 1'b0, ok);
        wait_done(ok);
        checks++;
        if ({max_index, max_value, elem_count} !== {21'd1, 8'hFF, 21'd8}) begin
            errors++;
            $display("FAIL negative_result: got idx=%0d val=%h cnt=%0d want idx=1 val=ff cnt=8",
                     max_index, max_value, elem_count);
        end
    endtask

    task automatic test_empty_vector();
        bit ok;
        int d0;
        do_start();
        d0 = done_pulses;
        send_beat(32'h12345678, 4'h0, 1'b1, 1'b1, ok);
        wait_done(ok);
        checks++;
        if (!ok || (done_pulses - d0 != 1)) begin
            errors++;
            $display("FAIL empty_done: got %0d pulses want 1", done_pulses - d0);
        end
        checks++;
        if ({max_index, max_value, elem_count} !== '0) begin
            errors++;
            $display("FAIL empty_result: got idx=%0d val=%h cnt=%0d want all zero",
                     max_index, max_value, elem_count);
        end
    endtask

    task automatic test_midrun_start();
        bit ok;
        do_start();
        send_beat(32'h7F7F7F7F, 4'hF, 1'b0, 1'b0, ok);
        send_beat(32'h7F7F7F7F, 4'hF, 1'b0, 1'b1, ok);
        start         = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h7F7F7F10;
        s_axis_tkeep  = 4'h1;
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL midrun_ready: got %b want 1", s_axis_tready); end
        @(posedge clk); #1;
        start         = 1'b0;
        s_axis_tvalid = 1'b0;
        wait_done(ok);
        checks++;
        if ({max_index, max_value, elem_count} !== {21'd0, 8'h10, 21'd1}) begin
            errors++;
            $display("FAIL midrun_result: got idx=%0d val=%h cnt=%0d want idx=0 val=10 cnt=1",
                     max_index, max_value, elem_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        do_start();
        m_axis_tready = 1'b0;
        send_beat(32'h11223344, 4'hF, 1'b0, 1'b0, ok);
        send_beat(32'h55667700, 4'hF, 1'b0, 1'b0, ok);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, s_axis_tready, busy, elem_count, max_value} !== '0) begin
            errors++;
            $display("FAIL reset_mid_packet: got mv=%b rdy=%b busy=%b cnt=%0d val=%h want all zero",
                     m_axis_tvalid, s_axis_tready, busy, elem_count, max_value);
        end
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_discard: got mv=%b want 0", m_axis_tvalid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ten_neurons();
        test_tie();
        test_back_to_back_backpressure();
        test_negative();
        test_empty_vector();
        test_midrun_start();
        test_reset_mid_packet();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending beats want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
